// File: rtl/cnd_pair.sv
// Cumulative normal pair N(d1), N(d2) in Q16.16 using the Abramowitz-Stegun 26.2.17 form.
// Operands are processed one after the other; the divider runs alongside the exponential block.

module cnd_exp (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [31:0] x,
  output logic signed [31:0] y,
  output logic               done
);

  typedef enum logic [1:0] {E_IDLE, E_SCALE, E_POLY, E_OUT} e_state_t;

  localparam logic signed [31:0] LOG2E = 32'sd94548;
  // Taylor coefficients of 2^f = e^(f*ln2), f in [0,1)
  localparam logic signed [31:0] C0 = 32'sd65536;
  localparam logic signed [31:0] C1 = 32'sd45426;
  localparam logic signed [31:0] C2 = 32'sd15744;
  localparam logic signed [31:0] C3 = 32'sd3638;
  localparam logic signed [31:0] C4 = 32'sd630;
  localparam logic signed [31:0] C5 = 32'sd87;
  localparam logic signed [31:0] C6 = 32'sd10;

  function automatic logic signed [31:0] mulq(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return 32'(p >>> 16);
  endfunction

  e_state_t state_reg, state_next;
  logic signed [31:0] x_reg, f_reg, p_reg, y_reg;
  logic [4:0]         sh_reg;
  logic               zero_reg;
  logic [2:0]         cnt_reg;

  logic signed [31:0] yl, coef, p_step;
  logic signed [15:0] k_int;

  always_comb begin
    yl    = mulq(x_reg, LOG2E);
    k_int = yl[31:16];
    case (cnt_reg)
      3'd0:    coef = C5;
      3'd1:    coef = C4;
      3'd2:    coef = C3;
      3'd3:    coef = C2;
      3'd4:    coef = C1;
      default: coef = C0;
    endcase
    p_step = coef + mulq(f_reg, p_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= E_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      E_IDLE:  if (start) state_next = E_SCALE;
      E_SCALE: state_next = E_POLY;
      E_POLY:  if (cnt_reg == 3'd5) state_next = E_OUT;
      E_OUT:   state_next = E_IDLE;
      default: state_next = E_IDLE;
    endcase
  end

  always_comb begin
    done = (state_reg == E_OUT);
    y    = y_reg;
  end

  // e^x = 2^k * 2^f with y = x*log2(e) = k + f; the input is never positive here
  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg    <= '0;
      f_reg    <= '0;
      p_reg    <= '0;
      y_reg    <= '0;
      sh_reg   <= '0;
      zero_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      case (state_reg)
        E_IDLE: if (start) x_reg <= x;
        E_SCALE: begin
          f_reg    <= {16'd0, yl[15:0]};
          sh_reg   <= 5'(-k_int);
          zero_reg <= (k_int < -16'sd31);
          p_reg    <= C6;
          cnt_reg  <= '0;
        end
        E_POLY: begin
          p_reg   <= p_step;
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg == 3'd5) y_reg <= zero_reg ? 32'sd0 : (p_step >>> sh_reg);
        end
        default: ;
      endcase
    end
  end

endmodule

module cnd_pair #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] CLAMP_MAG = 32'h0008_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] Nd1,
  output logic [WIDTH-1:0] Nd2,
  output logic             norm_done,
  output logic             busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETUP, S_DIV, S_HORN, S_EXPW, S_PHI, S_FIN, S_DONE
  } state_t;

  localparam logic signed [31:0] ONE = 32'sh0001_0000;
  localparam logic signed [31:0] P   = 32'sd15181;
  localparam logic signed [31:0] B1  = 32'sd20931;
  localparam logic signed [31:0] B2  = -32'sd23368;
  localparam logic signed [31:0] B3  = 32'sd116751;
  localparam logic signed [31:0] B4  = -32'sd119358;
  localparam logic signed [31:0] B5  = 32'sd87181;
  localparam logic signed [31:0] C   = 32'sd26145;

  function automatic logic signed [31:0] mulq(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return 32'(p >>> 16);
  endfunction

  state_t state_reg, state_next;

  logic signed [31:0] d1_reg, d2_reg, a_reg, exp_x_reg, den_reg;
  logic signed [31:0] q_reg, phi_reg, slot1_reg, nd1_reg, nd2_reg;
  logic [31:0]        rem_reg, quo_reg;
  logic [5:0]         cnt_reg;
  logic               op_reg, neg_reg, clamp_reg, exp_start_reg, exp_seen_reg;

  logic signed [31:0] exp_y;
  logic               exp_done;

  cnd_exp u_exp (
    .clk   (clk),
    .reset (reset),
    .start (exp_start_reg),
    .x     (exp_x_reg),
    .y     (exp_y),
    .done  (exp_done)
  );

  logic signed [31:0] x_cur, a_abs, exp_x_load, den_setup;
  logic signed [63:0] sq;
  logic               load_clamp, div_ge, exp_ready;
  logic [32:0]        rem_shift;
  logic [31:0]        rem_sub;
  logic signed [31:0] horn_coef, horn_prod, horn_next, phi_next;
  logic signed [31:0] prod_fin, diff_fin, n_sat, n_mag, n_fin;

  always_comb begin
    x_cur = op_reg ? d2_reg : d1_reg;
    // the most negative value has no positive twin; saturating it lands on the clamp path
    if (x_cur == 32'sh8000_0000)
      a_abs = 32'sh7FFF_FFFF;
    else if (x_cur[31])
      a_abs = -x_cur;
    else
      a_abs = x_cur;
    load_clamp = ($unsigned(a_abs) >= CLAMP_MAG);
    sq         = 64'(a_abs) * 64'(a_abs);
    exp_x_load = -32'(sq >>> 17);
    den_setup  = ONE + mulq(P, a_reg);

    rem_shift = {rem_reg, 1'b0};
    div_ge    = (rem_shift >= {1'b0, den_reg});
    rem_sub   = 32'(rem_shift - {1'b0, den_reg});

    case (cnt_reg)
      6'd0:    horn_coef = B4;
      6'd1:    horn_coef = B3;
      6'd2:    horn_coef = B2;
      default: horn_coef = B1;
    endcase
    horn_prod = mulq(quo_reg, q_reg);
    horn_next = (cnt_reg == 6'd4) ? horn_prod : horn_coef + horn_prod;
    phi_next  = mulq(C, exp_y);
    exp_ready = exp_seen_reg || exp_done;

    prod_fin = mulq(phi_reg, q_reg);
    diff_fin = ONE - prod_fin;
    if (diff_fin < 0)
      n_sat = 32'sd0;
    else if (diff_fin > ONE)
      n_sat = ONE;
    else
      n_sat = diff_fin;
    n_mag = clamp_reg ? ONE : n_sat;
    n_fin = neg_reg ? ONE - n_mag : n_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  state_next = load_clamp ? S_FIN : S_SETUP;
      S_SETUP: state_next = S_DIV;
      S_DIV:   if (cnt_reg == 6'd32) state_next = S_HORN;
      S_HORN:  if (cnt_reg == 6'd4) state_next = exp_ready ? S_PHI : S_EXPW;
      S_EXPW:  if (exp_ready) state_next = S_PHI;
      S_PHI:   state_next = S_FIN;
      S_FIN:   state_next = op_reg ? S_DONE : S_LOAD;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    norm_done = (state_reg == S_DONE);
    busy      = (state_reg != S_IDLE);
    Nd1       = nd1_reg;
    Nd2       = nd2_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d1_reg        <= '0;
      d2_reg        <= '0;
      a_reg         <= '0;
      exp_x_reg     <= '0;
      den_reg       <= '0;
      q_reg         <= '0;
      phi_reg       <= '0;
      slot1_reg     <= '0;
      nd1_reg       <= '0;
      nd2_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      cnt_reg       <= '0;
      op_reg        <= 1'b0;
      neg_reg       <= 1'b0;
      clamp_reg     <= 1'b0;
      exp_start_reg <= 1'b0;
      exp_seen_reg  <= 1'b0;
    end else begin
      exp_start_reg <= (state_next == S_SETUP);
      if (state_reg == S_SETUP)
        exp_seen_reg <= 1'b0;
      else if (exp_done)
        exp_seen_reg <= 1'b1;

      case (state_reg)
        S_IDLE: if (start) begin
          d1_reg <= d1;
          d2_reg <= d2;
          op_reg <= 1'b0;
        end
        S_LOAD: begin
          a_reg     <= a_abs;
          neg_reg   <= x_cur[31];
          clamp_reg <= load_clamp;
          exp_x_reg <= exp_x_load;
        end
        S_SETUP: begin
          den_reg <= den_setup;
          cnt_reg <= '0;
        end
        // first cycle seeds the remainder with bit 32 of the dividend 2^32, then 32 iterations
        S_DIV: begin
          if (cnt_reg == 6'd0) begin
            rem_reg <= 32'd1;
            quo_reg <= '0;
          end else begin
            rem_reg <= div_ge ? rem_sub : rem_shift[31:0];
            quo_reg <= {quo_reg[30:0], div_ge};
          end
          if (cnt_reg == 6'd32) begin
            cnt_reg <= '0;
            q_reg   <= B5;
          end else begin
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
        S_HORN: begin
          q_reg   <= horn_next;
          cnt_reg <= cnt_reg + 6'd1;
        end
        S_PHI: phi_reg <= phi_next;
        S_FIN: begin
          if (!op_reg) begin
            slot1_reg <= n_fin;
            op_reg    <= 1'b1;
          end else begin
            nd1_reg <= slot1_reg;
            nd2_reg <= n_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cnd_pair.sv
// Randomized bench for cnd_pair against a real-valued normal CDF model.
// Checks values, latency, busy/norm_done timing, output hold, start rejection and mid-run reset.

module tb_cnd_pair;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] d1, d2;
  logic [31:0] Nd1, Nd2;
  logic        norm_done, busy;

  int     n_tests = 0;
  int     n_fail  = 0;
  bit     prev_known;
  longint prev1, prev2;

  cnd_pair dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .d1        (d1),
    .d2        (d2),
    .Nd1       (Nd1),
    .Nd2       (Nd2),
    .norm_done (norm_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint expv,
                     input longint tol = 0);
    longint diff;
    diff = obs - expv;
    if (diff < 0) diff = -diff;
    n_tests++;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, expv, tol);
    end
  endtask

  function automatic bit is_clamp(input int x);
    longint ax;
    ax = (x < 0) ? -longint'(x) : longint'(x);
    return ax >= 64'sd524288;
  endfunction

  // N(x) from the Abramowitz-Stegun series evaluated in floating point
  function automatic longint ref_cnd(input int x);
    real z, t, poly, phi, n;
    if (is_clamp(x)) return (x < 0) ? 0 : 65536;
    z = real'(x) / 65536.0;
    if (z < 0.0) z = -z;
    t    = 1.0 / (1.0 + 0.2316419 * z);
    poly = t * (0.319381530 + t * (-0.356563782 + t * (1.781477937
           + t * (-1.821255978 + t * 1.330274429))));
    phi  = $exp(-z * z / 2.0) * 0.3989422804014327;
    n    = 1.0 - phi * poly;
    if (x < 0) n = 1.0 - n;
    return longint'($rtoi(n * 65536.0 + 0.5));
  endfunction

  task automatic run_op(input int a, input int b, input bit spam, input string tag,
                        input longint tol);
    int     lat, busy_bad, hold_bad, exp_lat;
    bit     seen;
    longint e1, e2;
    e1      = ref_cnd(a);
    e2      = ref_cnd(b);
    exp_lat = (is_clamp(a) ? 2 : 42) + (is_clamp(b) ? 2 : 42) + 1;
    d1 = a;
    d2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!spam) start = 1'b0;
    lat = 1; seen = 1'b0; busy_bad = 0; hold_bad = 0;
    while (lat < 300) begin
      @(negedge clk);
      if (norm_done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_bad++;
      if (prev_known && (longint'(Nd1) != prev1 || longint'(Nd2) != prev2)) hold_bad++;
      if (spam) begin
        d1 = $urandom;
        d2 = $urandom;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, seen ? lat : -1, exp_lat);
    chk({tag, "_busy_run"}, busy_bad, 0);
    if (prev_known) chk({tag, "_hold"}, hold_bad, 0);
    chk({tag, "_busy_done"}, busy, 1);
    chk({tag, "_nd1"}, longint'(Nd1), e1, is_clamp(a) ? 0 : tol);
    chk({tag, "_nd2"}, longint'(Nd2), e2, is_clamp(b) ? 0 : tol);
    $display("[TB] %s d1=%0d d2=%0d Nd1=%0d Nd2=%0d (ref %0d %0d) lat=%0d",
             tag, a, b, Nd1, Nd2, e1, e2, lat);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_single_pulse"}, norm_done, 0);
    prev_known = is_clamp(a) && is_clamp(b);
    prev1 = e1;
    prev2 = e2;
  endtask

  task automatic reset_mid();
    int pulses;
    d1 = 3 << 16;
    d2 = 1 << 16;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_nd1", longint'(Nd1), 0);
    chk("rst_nd2", longint'(Nd2), 0);
    chk("rst_done", norm_done, 0);
    pulses = 0;
    repeat (120) begin
      @(negedge clk);
      if (norm_done) pulses++;
    end
    chk("rst_no_done", pulses, 0);
    $display("[TB] reset_mid busy=%0d Nd1=%0d Nd2=%0d late_pulses=%0d", busy, Nd1, Nd2, pulses);
    prev_known = 1'b1;
    prev1 = 0;
    prev2 = 0;
  endtask

  initial begin
    int edge_vals[6];
    int ra, rb;
    edge_vals = '{int'(32'h8000_0000), int'(32'h7FFF_FFFF), 524288, -524288, 524287, -524287};
    reset = 1'b1;
    start = 1'b0;
    d1 = '0;
    d2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_nd1", longint'(Nd1), 0);
    chk("reset_nd2", longint'(Nd2), 0);
    chk("reset_done", norm_done, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    prev_known = 1'b1;
    prev1 = 0;
    prev2 = 0;

    run_op(0, 0, 1'b0, "zero", 32);
    chk("zero_nd1_spec", longint'(Nd1), 32768, 8);
    chk("zero_nd2_spec", longint'(Nd2), 32768, 8);

    run_op(65536, -65536, 1'b0, "one", 32);
    chk("one_nd1_spec", longint'(Nd1), 55138, 16);
    chk("one_nd2_spec", longint'(Nd2), 10398, 16);
    chk("one_sum", longint'(Nd1) + longint'(Nd2), 65536, 2);

    run_op(9 << 16, -(9 << 16), 1'b0, "nine", 0);
    run_op(32768, -131072, 1'b1, "spam", 32);
    reset_mid();
    run_op(131072, int'(32'h8000_0000), 1'b0, "post_rst", 32);

    for (int i = 0; i <= 32; i++)
      run_op(-262144 + 16384 * i, 262144 - 16384 * i, 1'b0, "sweep", 32);

    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(0, 1310720)) - 655360;
      rb = int'($urandom_range(0, 1310720)) - 655360;
      if ($urandom_range(0, 7) == 0) ra = edge_vals[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) rb = edge_vals[$urandom_range(0, 5)];
      run_op(ra, rb, 1'b0, "rand", 32);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
